shared_mem_rr_arbiter: RTL and testbench



---
 rtl/shared_mem_rr_arbiter.sv | 163 ++++++++++++++++
 tb/tb_shared_mem_rr_arbiter.sv | 332 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/shared_mem_rr_arbiter.sv
// Shared dual-port RAM arbiter: one core granted per cycle (fixed or round-robin),
// registered RAM ports, and a tag pipeline that routes read data back to the issuing core.

module shared_mem_rr_arbiter_lane #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              hit,
  input  logic              rd_a,
  input  logic              rd_b,
  input  logic [DATA_W-1:0] mem_a_dout,
  input  logic [DATA_W-1:0] mem_b_dout,
  output logic [DATA_W-1:0] a_rdata,
  output logic [DATA_W-1:0] b_rdata,
  output logic              rvalid
);
  always_ff @(posedge clk) begin
    if (rst) begin
      a_rdata <= '0;
      b_rdata <= '0;
      rvalid  <= 1'b0;
    end else begin
      rvalid <= hit;
      if (hit && rd_a) a_rdata <= mem_a_dout;
      if (hit && rd_b) b_rdata <= mem_b_dout;
    end
  end
endmodule

module shared_mem_rr_arbiter #(
  parameter int NUM_CORES = 4,
  parameter int ADDR_W    = 17,
  parameter int DATA_W    = 32,
  parameter int MEM_LAT   = 1,
  parameter int RR_MODE   = 1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_CORES-1:0]        req,
  output logic [NUM_CORES-1:0]        wait_o,
  input  logic [NUM_CORES*ADDR_W-1:0] a_addr,
  input  logic [NUM_CORES*DATA_W-1:0] a_din,
  input  logic [NUM_CORES-1:0]        a_we,
  input  logic [NUM_CORES*ADDR_W-1:0] b_addr,
  input  logic [NUM_CORES*DATA_W-1:0] b_din,
  input  logic [NUM_CORES-1:0]        b_we,
  output logic [NUM_CORES*DATA_W-1:0] a_rdata,
  output logic [NUM_CORES*DATA_W-1:0] b_rdata,
  output logic [NUM_CORES-1:0]        rvalid,
  output logic [ADDR_W-1:0]           mem_a_addr,
  output logic [ADDR_W-1:0]           mem_b_addr,
  output logic [DATA_W-1:0]           mem_a_din,
  output logic [DATA_W-1:0]           mem_b_din,
  output logic                        mem_a_we,
  output logic                        mem_b_we,
  input  logic [DATA_W-1:0]           mem_a_dout,
  input  logic [DATA_W-1:0]           mem_b_dout
);
  localparam int IW = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;

  typedef struct packed {
    logic          rd_a;
    logic          rd_b;
    logic [IW-1:0] id;
  } tag_t;

  logic [NUM_CORES-1:0][ADDR_W-1:0] a_addr_v, b_addr_v;
  logic [NUM_CORES-1:0][DATA_W-1:0] a_din_v, b_din_v;
  assign a_addr_v = a_addr;
  assign b_addr_v = b_addr;
  assign a_din_v  = a_din;
  assign b_din_v  = b_din;

  logic [IW-1:0]        rr_ptr, gnt_idx, cand;
  logic                 gnt_any;
  logic [NUM_CORES-1:0] grant;

  // Scan starts just past the last winner in RR mode, at index 0 in fixed mode.
  always_comb begin
    gnt_any = 1'b0;
    gnt_idx = '0;
    cand    = '0;
    for (int k = 1; k <= NUM_CORES; k++) begin
      cand = (RR_MODE != 0) ? IW'((int'(rr_ptr) + k) % NUM_CORES) : IW'(k - 1);
      if (!gnt_any && req[cand]) begin
        gnt_any = 1'b1;
        gnt_idx = cand;
      end
    end
  end

  always_comb begin
    grant = '0;
    if (gnt_any) grant[gnt_idx] = 1'b1;
  end

  assign wait_o = req & ~grant;

  always_ff @(posedge clk) begin
    if (rst) begin
      mem_a_addr <= '0;
      mem_b_addr <= '0;
      mem_a_din  <= '0;
      mem_b_din  <= '0;
      mem_a_we   <= 1'b0;
      mem_b_we   <= 1'b0;
      rr_ptr     <= IW'(NUM_CORES - 1);
    end else begin
      mem_a_we <= 1'b0;
      mem_b_we <= 1'b0;
      if (gnt_any) begin
        mem_a_addr <= a_addr_v[gnt_idx];
        mem_b_addr <= b_addr_v[gnt_idx];
        mem_a_din  <= a_din_v[gnt_idx];
        mem_b_din  <= b_din_v[gnt_idx];
        mem_a_we   <= a_we[gnt_idx];
        // Same-address double write: port A owns the word.
        mem_b_we   <= b_we[gnt_idx] &
                      ~(a_we[gnt_idx] && (a_addr_v[gnt_idx] == b_addr_v[gnt_idx]));
        rr_ptr     <= gnt_idx;
      end
    end
  end

  logic [MEM_LAT:0] vld_pipe;
  tag_t             tag_pipe [MEM_LAT+1];
  tag_t             new_tag;

  assign new_tag = '{rd_a: ~a_we[gnt_idx], rd_b: ~b_we[gnt_idx], id: gnt_idx};

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_pipe <= '0;
      for (int s = 0; s <= MEM_LAT; s++) tag_pipe[s] <= '0;
    end else begin
      vld_pipe    <= {vld_pipe[MEM_LAT-1:0], gnt_any};
      tag_pipe[0] <= new_tag;
      for (int s = 1; s <= MEM_LAT; s++) tag_pipe[s] <= tag_pipe[s-1];
    end
  end

  // The last stage lines up with the RAM dout for that access.
  tag_t ret;
  logic ret_vld;
  assign ret     = tag_pipe[MEM_LAT];
  assign ret_vld = vld_pipe[MEM_LAT];

  for (genvar i = 0; i < NUM_CORES; i++) begin : g_lane
    shared_mem_rr_arbiter_lane #(.DATA_W(DATA_W)) u_lane (
      .clk        (clk),
      .rst        (rst),
      .hit        (ret_vld && (ret.id == IW'(i))),
      .rd_a       (ret.rd_a),
      .rd_b       (ret.rd_b),
      .mem_a_dout (mem_a_dout),
      .mem_b_dout (mem_b_dout),
      .a_rdata    (a_rdata[i*DATA_W +: DATA_W]),
      .b_rdata    (b_rdata[i*DATA_W +: DATA_W]),
      .rvalid     (rvalid[i])
    );
  end
endmodule

// File: tb/tb_shared_mem_rr_arbiter.sv
// Bench for shared_mem_rr_arbiter: RAM model, vector table, directed corner cases,
// and a randomized run against a queue-based reference model.
module tb_shared_mem_rr_arbiter;
  localparam int N   = 4;
  localparam int AW  = 17;
  localparam int DW  = 32;
  localparam int LAT = 1;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [N-1:0]    req = '0;
  logic [N*AW-1:0] a_addr = '0, b_addr = '0;
  logic [N*DW-1:0] a_din = '0, b_din = '0;
  logic [N-1:0]    a_we = '0, b_we = '0;
  logic [N-1:0]    wait_o, rvalid;
  logic [N*DW-1:0] a_rdata, b_rdata;
  logic [AW-1:0]   mem_a_addr, mem_b_addr;
  logic [DW-1:0]   mem_a_din, mem_b_din, mem_a_dout, mem_b_dout;
  logic            mem_a_we, mem_b_we;

  // fixed-priority twin, used only for its grant behaviour
  logic [N-1:0]    fx_wait, fx_rvalid;
  logic [N*DW-1:0] fx_a_rdata, fx_b_rdata;
  logic [AW-1:0]   fx_a_addr, fx_b_addr;
  logic [DW-1:0]   fx_a_din, fx_b_din;
  logic            fx_a_we, fx_b_we;
  logic [DW-1:0]   fx_dout = '0;

  always #5 clk = ~clk;

  shared_mem_rr_arbiter #(.NUM_CORES(N), .ADDR_W(AW), .DATA_W(DW), .MEM_LAT(LAT), .RR_MODE(1)) dut (
    .clk(clk), .rst(rst), .req(req), .wait_o(wait_o),
    .a_addr(a_addr), .a_din(a_din), .a_we(a_we),
    .b_addr(b_addr), .b_din(b_din), .b_we(b_we),
    .a_rdata(a_rdata), .b_rdata(b_rdata), .rvalid(rvalid),
    .mem_a_addr(mem_a_addr), .mem_b_addr(mem_b_addr),
    .mem_a_din(mem_a_din), .mem_b_din(mem_b_din),
    .mem_a_we(mem_a_we), .mem_b_we(mem_b_we),
    .mem_a_dout(mem_a_dout), .mem_b_dout(mem_b_dout));

  shared_mem_rr_arbiter #(.NUM_CORES(N), .ADDR_W(AW), .DATA_W(DW), .MEM_LAT(LAT), .RR_MODE(0)) dut_fx (
    .clk(clk), .rst(rst), .req(req), .wait_o(fx_wait),
    .a_addr(a_addr), .a_din(a_din), .a_we(a_we),
    .b_addr(b_addr), .b_din(b_din), .b_we(b_we),
    .a_rdata(fx_a_rdata), .b_rdata(fx_b_rdata), .rvalid(fx_rvalid),
    .mem_a_addr(fx_a_addr), .mem_b_addr(fx_b_addr),
    .mem_a_din(fx_a_din), .mem_b_din(fx_b_din),
    .mem_a_we(fx_a_we), .mem_b_we(fx_b_we),
    .mem_a_dout(fx_dout), .mem_b_dout(fx_dout));

  // Dual-port RAM: read-first, LAT cycles from registered address to dout.
  bit [DW-1:0] ram [256];
  bit [DW-1:0] ra_pipe [LAT];
  bit [DW-1:0] rb_pipe [LAT];
  always @(posedge clk) begin
    ra_pipe[0] <= ram[mem_a_addr[7:0]];
    rb_pipe[0] <= ram[mem_b_addr[7:0]];
    for (int k = 1; k < LAT; k++) begin
      ra_pipe[k] <= ra_pipe[k-1];
      rb_pipe[k] <= rb_pipe[k-1];
    end
    if (mem_a_we) ram[mem_a_addr[7:0]] <= mem_a_din;
    if (mem_b_we) ram[mem_b_addr[7:0]] <= mem_b_din;
  end
  assign mem_a_dout = ra_pipe[LAT-1];
  assign mem_b_dout = rb_pipe[LAT-1];

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic drive(input int c, input bit r, input logic [AW-1:0] aa, input logic [DW-1:0] ad,
                       input bit aw, input logic [AW-1:0] ba, input logic [DW-1:0] bd, input bit bw);
    req[c] = r;
    a_addr[c*AW +: AW] = aa; a_din[c*DW +: DW] = ad; a_we[c] = aw;
    b_addr[c*AW +: AW] = ba; b_din[c*DW +: DW] = bd; b_we[c] = bw;
  endtask

  task automatic do_reset();
    req = '0; a_we = '0; b_we = '0;
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    int          due;
    int          core;
    bit          ra;
    bit          rb;
    logic [DW-1:0] da;
    logic [DW-1:0] db;
  } cpl_t;
  cpl_t          q[$];
  bit [DW-1:0]   ref_mem [256];
  logic [N*DW-1:0] m_a_rd, m_b_rd;
  int            last;

  // winner = requester with the smallest rotational distance past the last winner
  function automatic int pick(input logic [N-1:0] r, input int lst);
    int best, bd, d;
    best = -1; bd = N;
    for (int i = 0; i < N; i++) begin
      if (r[i]) begin
        d = (i - lst - 1 + 2*N) % N;
        if (d < bd) begin bd = d; best = i; end
      end
    end
    return best;
  endfunction

  task automatic check_cycle();
    logic [N-1:0] exp_rv;
    cpl_t e;
    exp_rv = '0;
    if (q.size() > 0 && q[0].due == cyc) begin
      e = q.pop_front();
      exp_rv[e.core] = 1'b1;
      if (e.ra) m_a_rd[e.core*DW +: DW] = e.da;
      if (e.rb) m_b_rd[e.core*DW +: DW] = e.db;
    end
    chk("rnd_rvalid", rvalid, exp_rv);
    chk("rnd_a_rdata", a_rdata, m_a_rd);
    chk("rnd_b_rdata", b_rdata, m_b_rd);
  endtask

  typedef struct {
    logic [N-1:0] req;
    logic [N-1:0] exp_rr;
    logic [N-1:0] exp_fx;
  } vec_t;
  vec_t tbl [12];

  int got [8];
  int ngot;
  int exp_ord [7];

  initial begin
    logic [N-1:0] g_v, acc, exp_w;
    int g, bad, seen3, npulse;
    logic [AW-1:0] p_aa, p_ba;
    bit p_vld, p_awe, p_bwe;

    tbl[0]  = '{4'b1111, 4'b1110, 4'b1110};
    tbl[1]  = '{4'b1111, 4'b1101, 4'b1110};
    tbl[2]  = '{4'b1010, 4'b0010, 4'b1000};
    tbl[3]  = '{4'b0011, 4'b0010, 4'b0010};
    tbl[4]  = '{4'b0000, 4'b0000, 4'b0000};
    tbl[5]  = '{4'b0001, 4'b0000, 4'b0000};
    tbl[6]  = '{4'b0101, 4'b0001, 4'b0100};
    tbl[7]  = '{4'b1001, 4'b0001, 4'b1000};
    tbl[8]  = '{4'b1000, 4'b0000, 4'b0000};
    tbl[9]  = '{4'b1100, 4'b1000, 4'b1000};
    tbl[10] = '{4'b1011, 4'b0011, 4'b1010};
    tbl[11] = '{4'b0110, 4'b0100, 4'b0100};
    exp_ord = '{0, 1, 2, 3, 0, 1, 3};

    // reset held with all cores requesting
    req = 4'b1111;
    for (int c = 0; c < 3; c++) begin
      tick();
      chk("rst_wait", wait_o, 4'b1110);
      chk("rst_mem", {mem_a_addr, mem_b_addr, mem_a_din, mem_b_din, mem_a_we, mem_b_we}, '0);
      chk("rst_rdata", {a_rdata, b_rdata, rvalid}, '0);
    end
    rst = 1'b0; req = '0;
    bad = 0;
    for (int c = 0; c < 5; c++) begin tick(); if (rvalid != 0) bad++; end
    chk("post_rst_rvalid", bad, 0);

    // preload 0x10/0x11 through core 1, then core 2 reads them back
    drive(1, 1, 17'h10, 32'hDEADBEEF, 1, 17'h11, 32'h12345678, 1);
    #1 chk("wr_wait", wait_o, 4'b0000);
    tick(); req = '0;
    for (int c = 0; c < LAT + 3; c++) tick();
    drive(2, 1, 17'h10, 32'h0, 0, 17'h11, 32'h0, 0);
    #1 chk("rd_wait", wait_o, 4'b0000);
    tick(); req = '0;
    chk("rd_mem_addr", {mem_a_addr, mem_b_addr, mem_a_we, mem_b_we}, {17'h10, 17'h11, 2'b00});
    for (int k = 2; k <= LAT + 3; k++) begin
      tick();
      chk("rd_rvalid", rvalid, (k == LAT + 2) ? 4'b0100 : 4'b0000);
    end
    chk("rd_a_data", a_rdata[2*DW +: DW], 32'hDEADBEEF);
    chk("rd_b_data", b_rdata[2*DW +: DW], 32'h12345678);

    // vector table: RR and fixed-priority grant per cycle
    do_reset();
    for (int i = 0; i < 12; i++) begin
      for (int c = 0; c < N; c++) drive(c, tbl[i].req[c], '0, '0, 0, '0, '0, 0);
      #1;
      chk($sformatf("tbl%0d_rr", i), wait_o, tbl[i].exp_rr);
      chk($sformatf("tbl%0d_fx", i), fx_wait, tbl[i].exp_fx);
      tick();
    end

    // RR fairness: cores drop req after acceptance
    do_reset();
    ngot = 0;
    req = 4'b1111;
    for (int c = 0; c < 20 && ngot < 7; c++) begin
      if (ngot == 4 && req == 0) req = 4'b0001;
      else if (ngot == 5 && req == 0) req = 4'b1011;
      #1;
      g_v = req & ~wait_o;
      for (int i = 0; i < N; i++) if (g_v[i] && ngot < 8) begin got[ngot] = i; ngot++; end
      tick();
      req = req & ~g_v;
    end
    req = '0;
    chk("rr_count", ngot, 7);
    for (int i = 0; i < 7; i++) chk($sformatf("rr_order%0d", i), got[i], exp_ord[i]);

    // withdrawal: core 3 waits two cycles then drops
    do_reset();
    drive(0, 1, 17'h30, 0, 0, 17'h31, 0, 0);
    drive(1, 1, 17'h32, 0, 0, 17'h33, 0, 0);
    drive(2, 1, 17'h34, 0, 0, 17'h35, 0, 0);
    drive(3, 1, 17'h77, 32'h3333, 1, 17'h78, 32'h4444, 1);
    #1 chk("wd_wait0", wait_o, 4'b1110);
    bad = 0; seen3 = 0; npulse = 0;
    for (int c = 0; c < 10; c++) begin
      tick();
      if (mem_a_addr == 17'h77 || mem_b_addr == 17'h78) bad++;
      if (rvalid[3]) seen3++;
      npulse += $countones(rvalid);
      if (c == 0) begin req[0] = 0; #1 chk("wd_wait1", wait_o, 4'b1100); end
      if (c == 1) begin req[1] = 0; req[3] = 0; #1 chk("wd_wait2", wait_o, 4'b0000); end
      if (c == 2) req = '0;
    end
    chk("wd_no_mem", bad, 0);
    chk("wd_no_rvalid3", seen3, 0);
    chk("wd_pulses", npulse, 3);

    // same-address double write: A wins
    do_reset();
    drive(1, 1, 17'h20, 32'hAAAA, 1, 17'h20, 32'hBBBB, 1);
    #1;
    tick(); req = '0;
    chk("cf_we", {mem_a_we, mem_b_we}, 2'b10);
    chk("cf_a", {mem_a_addr, mem_a_din}, {17'h20, 32'hAAAA});
    for (int k = 2; k <= LAT + 2; k++) tick();
    chk("cf_ack", rvalid, 4'b0010);
    chk("cf_no_capture", a_rdata[DW +: DW], 32'h0);
    drive(1, 1, 17'h20, 0, 0, 17'h21, 0, 0);
    #1;
    tick(); req = '0;
    for (int k = 2; k <= LAT + 2; k++) tick();
    chk("cf_rd_rvalid", rvalid, 4'b0010);
    chk("cf_rd_data", a_rdata[DW +: DW], 32'hAAAA);

    // reset mid-flight drops the read
    do_reset();
    drive(0, 1, 17'h10, 0, 0, 17'h11, 0, 0);
    #1 chk("mf_wait", wait_o, 4'b0000);
    tick(); req = '0; rst = 1'b1;
    tick(); rst = 1'b0;
    bad = 0;
    for (int c = 0; c < 6; c++) begin tick(); if (rvalid != 0) bad++; end
    chk("mf_no_rvalid", bad, 0);
    chk("mf_rdata", a_rdata[0 +: DW], 32'h0);

    // randomized run vs. reference model (addresses 0x40..0x4f start as zero)
    do_reset();
    q.delete();
    m_a_rd = '0; m_b_rd = '0;
    last = N - 1;
    acc = '0; p_vld = 0; p_aa = '0; p_ba = '0; p_awe = 0; p_bwe = 0;
    for (int t = 0; t < 1500 + LAT + 4; t++) begin
      tick();
      check_cycle();
      if (p_vld) begin
        chk("rnd_mem_addr", {mem_a_addr, mem_b_addr}, {p_aa, p_ba});
        chk("rnd_mem_we", {mem_a_we, mem_b_we}, {p_awe, p_bwe});
      end else
        chk("rnd_mem_idle", {mem_a_we, mem_b_we}, 2'b00);
      for (int c = 0; c < N; c++) begin
        if (t >= 1500) req[c] = 0;
        else if (acc[c] || !req[c]) begin
          logic [AW-1:0] aa, ba;
          bit aw, bw;
          aa = AW'(8'h40 + $urandom_range(0, 15));
          ba = AW'(8'h40 + $urandom_range(0, 15));
          aw = 1'($urandom_range(0, 1));
          bw = (aa == ba) ? aw : 1'($urandom_range(0, 1));
          drive(c, 1'($urandom_range(0, 1)), aa, $urandom, aw, ba, $urandom, bw);
        end else if ($urandom_range(0, 15) == 0) req[c] = 0;
      end
      #1;
      g = pick(req, last);
      exp_w = req;
      if (g >= 0) exp_w[g] = 1'b0;
      chk("rnd_wait", wait_o, exp_w);
      acc = req & ~wait_o;
      p_vld = (g >= 0);
      if (g >= 0) begin
        cpl_t e;
        logic [AW-1:0] aa, ba;
        last = g;
        aa = a_addr[g*AW +: AW];
        ba = b_addr[g*AW +: AW];
        e.due = cyc + 2 + LAT; e.core = g;
        e.ra = !a_we[g]; e.rb = !b_we[g];
        e.da = ref_mem[aa[7:0]]; e.db = ref_mem[ba[7:0]];
        if (a_we[g]) ref_mem[aa[7:0]] = a_din[g*DW +: DW];
        if (b_we[g] && !(a_we[g] && aa == ba)) ref_mem[ba[7:0]] = b_din[g*DW +: DW];
        q.push_back(e);
        p_aa = aa; p_ba = ba;
        p_awe = a_we[g]; p_bwe = b_we[g] && !(a_we[g] && aa == ba);
      end
    end
    chk("rnd_drained", q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
